// File: rtl/ext_target_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : ext_target_pipe_if
// Brief    : Upstream/downstream handshake bundle for the ID->EX extension and
//            control-target pipeline.
// Revision : 1.0 - initial release
// ============================================================================
interface ext_target_pipe_if #(
    parameter int DATA_W = 32
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [DATA_W-1:0] in_pc;
    logic [2:0]        in_op;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_imm;
    logic [DATA_W-1:0] out_target;
    logic [2:0]        out_op;
    logic              out_err;

    modport master (
        output flush, in_valid, in_instr, in_pc, in_op, out_ready,
        input  in_ready, out_valid, out_imm, out_target, out_op, out_err
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, in_op, out_ready,
        output in_ready, out_valid, out_imm, out_target, out_op, out_err
    );
endinterface
`default_nettype wire

// File: rtl/ext_target_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ext_target_pipe
// Brief    : Two-stage immediate extender and jump/branch target generator
//            with valid/ready handshake and synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module ext_target_pipe #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int JIDX_W = 26,
    parameter int LUI_SH = 16
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    ext_target_pipe_if.slave   bus
);
    localparam logic [2:0] c_op_zext   = 3'b000;
    localparam logic [2:0] c_op_sext   = 3'b001;
    localparam logic [2:0] c_op_lui    = 3'b010;
    localparam logic [2:0] c_op_jump   = 3'b011;
    localparam logic [2:0] c_op_branch = 3'b100;

    // Stage 1 state
    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_ext_q,   s1_ext_d;
    logic [DATA_W-1:0] s1_pc4_q,   s1_pc4_d;
    logic [2:0]        s1_op_q,    s1_op_d;
    logic [JIDX_W-1:0] s1_jidx_q,  s1_jidx_d;
    logic              s1_err_q,   s1_err_d;

    // Stage 2 state (drives the outputs directly)
    logic              s2_valid_q,  s2_valid_d;
    logic [DATA_W-1:0] s2_imm_q,    s2_imm_d;
    logic [DATA_W-1:0] s2_target_q, s2_target_d;
    logic [2:0]        s2_op_q,     s2_op_d;
    logic              s2_err_q,    s2_err_d;

    logic              w_s1_advance;
    logic              w_in_ready;
    logic [IMM_W-1:0]  w_imm;
    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_lui;
    logic [DATA_W-1:0] w_ext;
    logic              w_err;
    logic [DATA_W-1:0] w_target;
    logic              w_unused_instr;

    // Ready depends only on registered state, never on in_valid.
    assign w_s1_advance = !s2_valid_q || bus.out_ready;
    assign w_in_ready   = !s1_valid_q || w_s1_advance;

    assign w_imm  = bus.in_instr[IMM_W-1:0];
    assign w_zext = {{(DATA_W-IMM_W){1'b0}}, w_imm};
    assign w_sext = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
    assign w_lui  = w_zext << LUI_SH;

    assign w_unused_instr = ^bus.in_instr[31:JIDX_W];

    always_comb begin
        w_ext = '0;
        w_err = 1'b0;
        case (bus.in_op)
            c_op_zext:   w_ext = w_zext;
            c_op_sext:   w_ext = w_sext;
            c_op_lui:    w_ext = w_lui;
            c_op_jump:   w_ext = w_sext;
            c_op_branch: w_ext = w_sext;
            default:     w_err = 1'b1;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_ext_d   = s1_ext_q;
        s1_pc4_d   = s1_pc4_q;
        s1_op_d    = s1_op_q;
        s1_jidx_d  = s1_jidx_q;
        s1_err_d   = s1_err_q;
        if (w_in_ready) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_ext_d  = w_ext;
                s1_pc4_d  = bus.in_pc + DATA_W'(4);
                s1_op_d   = bus.in_op;
                s1_jidx_d = bus.in_instr[JIDX_W-1:0];
                s1_err_d  = w_err;
            end
        end
        if (bus.flush) begin
            s1_valid_d = 1'b0;
        end
    end

    // Jump keeps the region bits of PC+4, not of the instruction's own PC.
    always_comb begin
        w_target = '0;
        case (s1_op_q)
            c_op_jump:   w_target = {s1_pc4_q[DATA_W-1:JIDX_W+2], s1_jidx_q, 2'b00};
            c_op_branch: w_target = s1_pc4_q + (s1_ext_q << 2);
            default:     w_target = '0;
        endcase
    end

    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_imm_d    = s2_imm_q;
        s2_target_d = s2_target_q;
        s2_op_d     = s2_op_q;
        s2_err_d    = s2_err_q;
        if (w_s1_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_imm_d    = s1_ext_q;
                s2_target_d = w_target;
                s2_op_d     = s1_op_q;
                s2_err_d    = s1_err_q;
            end
        end
        if (bus.flush) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_ext_q    <= '0;
            s1_pc4_q    <= '0;
            s1_op_q     <= '0;
            s1_jidx_q   <= '0;
            s1_err_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_imm_q    <= '0;
            s2_target_q <= '0;
            s2_op_q     <= '0;
            s2_err_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_ext_q    <= s1_ext_d;
            s1_pc4_q    <= s1_pc4_d;
            s1_op_q     <= s1_op_d;
            s1_jidx_q   <= s1_jidx_d;
            s1_err_q    <= s1_err_d;
            s2_valid_q  <= s2_valid_d;
            s2_imm_q    <= s2_imm_d;
            s2_target_q <= s2_target_d;
            s2_op_q     <= s2_op_d;
            s2_err_q    <= s2_err_d;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = s2_valid_q;
    assign bus.out_imm    = s2_imm_q;
    assign bus.out_target = s2_target_q;
    assign bus.out_op     = s2_op_q;
    assign bus.out_err    = s2_err_q;
endmodule
`default_nettype wire

// File: tb/tb_ext_target_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_target_pipe
// Brief    : Scoreboard bench for ext_target_pipe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ext_target_pipe;
    typedef struct packed {
        logic [31:0] imm;
        logic [31:0] target;
        logic [2:0]  op;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   n_out;
    exp_t sb[$];

    ext_target_pipe_if #(.DATA_W(32)) bus ();

    ext_target_pipe #(
        .DATA_W (32),
        .IMM_W  (16),
        .JIDX_W (26),
        .LUI_SH (16)
    ) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] instr,
                                   input logic [31:0] pc);
        exp_t        e;
        logic [31:0] pc4;
        logic [31:0] se;
        pc4      = pc + 32'd4;
        se       = {{16{instr[15]}}, instr[15:0]};
        e.imm    = 32'h0;
        e.target = 32'h0;
        e.op     = op;
        e.err    = 1'b0;
        case (op)
            3'd0: e.imm = {16'h0, instr[15:0]};
            3'd1: e.imm = se;
            3'd2: e.imm = {instr[15:0], 16'h0};
            3'd3: begin e.imm = se; e.target = {pc4[31:28], instr[25:0], 2'b00}; end
            3'd4: begin e.imm = se; e.target = pc4 + {se[29:0], 2'b00}; end
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    // Output side: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready && !bus.flush) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", bus.out_imm, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_imm",    bus.out_imm,    e.imm);
                chk("out_target", bus.out_target, e.target);
                chk("out_op",     {29'h0, bus.out_op}, {29'h0, e.op});
                chk("out_err",    {31'h0, bus.out_err}, {31'h0, e.err});
                n_out++;
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [31:0] instr, input logic [31:0] pc);
        int t;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_instr = instr;
        bus.in_pc    = pc;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) chk("send_timeout", 32'd0, 32'd1);
        else sb.push_back(model(op, instr, pc));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        n_cmp = 0;
        n_bad = 0;
        n_out = 0;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'h0;
        bus.in_pc     = 32'h0;
        bus.in_op     = 3'd0;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_out_valid",  {31'h0, bus.out_valid}, 32'h0);
        chk("rst_out_imm",    bus.out_imm, 32'h0);
        chk("rst_out_target", bus.out_target, 32'h0);
        chk("rst_out_op_err", {28'h0, bus.out_op, bus.out_err}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);

        // Sign-extend with two-edge latency
        send(3'd1, 32'h0000_8001, 32'h0000_1000);
        chk("lat_s1_only", {31'h0, bus.out_valid}, 32'h0);
        @(posedge clk);
        #1;
        chk("lat_two_edges", {31'h0, bus.out_valid}, 32'h1);
        drain();

        // Back-to-back mix of modes
        send(3'd4, 32'h0000_FFFF, 32'h0000_3000);
        send(3'd2, 32'h0000_1234, 32'h0000_0040);
        send(3'd0, 32'h0000_ABCD, 32'h0000_0080);
        send(3'd3, 32'h0000_0C01, 32'hF000_3000);
        send(3'd3, 32'h0000_0C01, 32'hFFFF_FFFC);
        send(3'd4, 32'h0000_7FFF, 32'hFFFF_FFF0);
        drain();

        // Backpressure: two held, third waits
        bus.out_ready = 1'b0;
        n0 = n_out;
        send(3'd0, 32'h0000_1111, 32'h0000_0100);
        chk("bp_ready_after_1", {31'h0, bus.in_ready}, 32'h1);
        send(3'd1, 32'h0000_2222, 32'h0000_0200);
        chk("bp_ready_after_2", {31'h0, bus.in_ready}, 32'h0);
        fork
            send(3'd4, 32'h0000_0010, 32'h0000_0100);
        join_none
        repeat (3) begin
            @(negedge clk);
            chk("bp_frozen_valid", {31'h0, bus.out_valid}, 32'h1);
            chk("bp_frozen_imm",   bus.out_imm, 32'h0000_1111);
            chk("bp_in_ready",     {31'h0, bus.in_ready}, 32'h0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait fork;
        drain();
        chk("bp_count", n_out - n0, 32'd3);

        // Flush with two in flight plus a new input
        bus.out_ready = 1'b0;
        send(3'd0, 32'h0000_0AAA, 32'h0000_0000);
        send(3'd0, 32'h0000_0BBB, 32'h0000_0000);
        bus.in_valid  = 1'b1;
        bus.in_op     = 3'd0;
        bus.in_instr  = 32'h0000_0CCC;
        bus.flush     = 1'b1;
        @(posedge clk);
        #1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        sb.delete();
        chk("flush_out_valid", {31'h0, bus.out_valid}, 32'h0);
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send(3'd1, 32'h0000_0DDD, 32'h0000_0000);
        chk("flush_lat_early", {31'h0, bus.out_valid}, 32'h0);
        @(posedge clk);
        #1;
        chk("flush_lat", {31'h0, bus.out_valid}, 32'h1);
        drain();

        // Illegal mode flows through with err set
        send(3'd6, 32'hFFFF_FFFF, 32'h0000_4000);
        send(3'd7, 32'h0000_1234, 32'h0000_5000);
        drain();

        // Asynchronous reset mid-stream
        bus.out_ready = 1'b0;
        send(3'd1, 32'h0000_9999, 32'h0000_0000);
        send(3'd2, 32'h0000_7777, 32'h0000_0000);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("async_rst_imm",   bus.out_imm, 32'h0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", {31'h0, bus.in_ready}, 32'h1);
        chk("post_rst_valid", {31'h0, bus.out_valid}, 32'h0);
        n0 = n_out;
        send(3'd0, 32'h0000_5A5A, 32'h0000_0000);
        drain();
        chk("post_rst_count", n_out - n0, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ext_target_pipe.md
Name: ext_target_pipe

Overview:
- Parametrised, two-stage pipelined immediate-extension and control-target unit for the ID→EX boundary of the MIPS pipeline.
- Per accepted instruction it produces:
  - the extended immediate (zero, sign or LUI).
  - the jump or branch target, computed from PC+4.
- Both results come out of registers, behind a valid/ready handshake with flush.
- Replaces the combinational extender. Target addition is moved off the ID critical path and supports decode-stage stalls.

Parameters:
- DATA_W, 32, datapath/PC width; legal ≥ 32.
- IMM_W, 16, immediate field width taken from in_instr[IMM_W-1:0].
- JIDX_W, 26, jump index field width taken from in_instr[JIDX_W-1:0].
- LUI_SH, 16, left shift applied in LUI mode.

Ports:
- clk  in  1  clock.
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- flush  in  1  synchronous kill of all in-flight entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  unit can accept this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  DATA_W  PC of the instruction.
- in_op  in  3  mode: 000 zero-ext, 001 sign-ext, 010 LUI, 011 jump, 100 branch; 101–111 illegal.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  DATA_W  extended immediate.
- out_target  out  DATA_W  jump/branch target; 0 for modes 000–010.
- out_op  out  3  echoed mode.
- out_err  out  1  entry carried an illegal mode.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Both stage valid bits cleared; out_valid=0.
  - out_imm, out_target, out_op and out_err are all 0.
  - in_ready=1 from the first cycle after release.
- Handshake:
  - Transfer in occurs when in_valid & in_ready; transfer out when out_valid & out_ready.
  - in_ready = !s1_valid | s1_advance.
  - s1_advance = !s2_valid | out_ready.
  - in_ready contains no combinational path from in_valid.
- Stage 1 (registered on accept):
  - pc4 = in_pc + 4, modulo 2^DATA_W.
  - ext by mode:
    - 000: zero-pad imm to DATA_W.
    - 001: sign-extend from bit IMM_W-1.
    - 010: zero-ext(imm) << LUI_SH.
    - 011: ext = sign-extended imm (don't-care for the target).
    - 100: sign-extend, as 001.
    - 101–111: ext = 0, err = 1.
  - Register s1_ext, s1_pc4, s1_op, s1_jidx and s1_err.
- Stage 2 (registered on s1_advance & s1_valid):
  - out_imm = s1_ext.
  - Jump target = {pc4[DATA_W-1:JIDX_W+2], jidx, 2'b00}. Upper bits come from PC+4, not PC.
  - Branch target = pc4 + (s1_ext << 2), modulo 2^DATA_W.
  - Target for all other modes is 0.
- Latency:
  - Input accepted at edge N appears with out_valid=1 after edge N+1 when out_ready stays high.
  - Throughput is 1 per cycle.
- Backpressure:
  - With out_ready low, stage 2 holds its contents and outputs stable.
  - Stage 1 fills, then in_ready drops: at most 2 entries are held.
  - No entry is dropped or duplicated.
- Flush:
  - Clears s1_valid and s2_valid at the next edge; out_valid=0 in the following cycle.
  - An input presented in the same cycle as flush is discarded.
  - Flush wins over simultaneous accept/advance.
  - Data registers need not clear on flush.
- Simultaneous events:
  - Accept into stage 1 while stage 1 advances into stage 2 is legal (pipeline moves).
  - Output drain and refill in the same cycle is legal.
- Reset mid-operation discards all entries immediately, asynchronously.
- Illegal mode: the entry flows normally with out_err=1, out_imm=0 and out_target=0. No stall.

Test Plan:
- Reset with out_valid held low, then release; send op=001, instr[15:0]=0x8001 with out_ready=1 → two edges later: out_valid=1, out_imm=0xFFFF8001, out_target=0.
- Send op=100, pc=0x00003000, imm=0xFFFF → out_target=0x00003000, out_imm=0xFFFFFFFF. Send op=010, imm=0x1234 → out_imm=0x12340000.
- Send op=011, pc=0xF0003000, jidx=0x0000C01 → out_target=0xF0003004. Also send pc=0xFFFFFFFC: pc4 wraps to 0, so jidx=0x0000C01 gives target 0x00003004.
- Backpressure: hold out_ready=0 and send 3 back-to-back entries:
  - in_ready must fall after the 2nd accept.
  - Outputs stay frozen on entry 1.
  - After releasing out_ready, entries 1, 2, 3 appear in order, exactly once each.
- Assert flush for one cycle with 2 entries in flight plus in_valid=1 → out_valid=0 next cycle. The flushed input never emerges, and the next input flows with 2-cycle latency.
- Send op=110 → out_err=1, out_imm=0, out_target=0. Separately, pulse reset_n low mid-stream → out_valid=0 immediately without waiting for clk.
